// File: rtl/sync_up_counter_mod.sv
// sync_up_counter_mod
// Modulo-MODULUS synchronous binary up counter with clock enable,
// synchronous clear, parallel load and a combinational carry-out for
// cascading. The next state is formed by plain combinational logic and
// captured by one D flip-flop per state bit. q comes straight from those
// flops. Per-edge priority, highest first: reset, clear, load, en.
module sync_up_counter_mod #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped,
    output logic             load_err
);

    // Terminal count value, and the modulus widened by one bit.
    // The extra bit lets MODULUS = 2**WIDTH be held without truncation.
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_ff;
    logic             wrapped_ff;
    logic             load_err_ff;

    logic [WIDTH-1:0] q_nxt;
    logic             wrapped_nxt;
    logic             load_err_nxt;

    logic             at_last;
    logic             q_in_range;
    logic             load_ok;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_loaded;

    // Decodes of the current count and the load value.
    // Range checks are done at WIDTH+1 bits so every legal MODULUS compares correctly.
    assign at_last    = (q_ff == LAST);
    assign q_in_range = ({1'b0, q_ff} < MOD_EXT);
    assign load_ok    = ({1'b0, load_val} < MOD_EXT);

    // WIDTH-bit increment. The terminal-count compare overrides natural
    // overflow. Any out-of-range count is also pulled back to zero.
    assign q_inc    = q_ff + WIDTH'(1);
    assign q_step   = (at_last || !q_in_range) ? '0 : q_inc;

    // An illegal load value lands the counter on zero instead.
    assign q_loaded = load_ok ? load_val : '0;

    // Carry-out has no register stage. The next cascaded stage then
    // increments on the same edge as this stage wraps.
    assign tc = en & at_last;

    // Next-state selection in priority order: reset, clear, load, en, hold.
    always_comb begin
        q_nxt        = q_ff;
        wrapped_nxt  = 1'b0;
        load_err_nxt = 1'b0;
        if (reset || clear) begin
            q_nxt = '0;
        end else if (load) begin
            q_nxt        = q_loaded;
            load_err_nxt = !load_ok;
        end else if (en) begin
            q_nxt       = q_step;
            // No wrap pulse when recovering from an out-of-range count.
            wrapped_nxt = at_last;
        end
    end

    // State flip-flops. Reset is already folded into the next-state terms,
    // so every bit is a plain D flop.
    always_ff @(posedge clk) begin
        q_ff        <= q_nxt;
        wrapped_ff  <= wrapped_nxt;
        load_err_ff <= load_err_nxt;
    end

    assign q        = q_ff;
    assign wrapped  = wrapped_ff;
    assign load_err = load_err_ff;

endmodule

// File: tb/tb_sync_up_counter_mod.sv
// tb_sync_up_counter_mod
// Directed-vector bench for sync_up_counter_mod. It drives three setups:
// a MODULUS=8 counter, a MODULUS=6 counter, and a two-stage MODULUS=8
// cascade in which the upper stage is enabled by the lower stage's tc.
// Every expected value is computed by hand in the vectors below.
module tb_sync_up_counter_mod;

    logic clk = 1'b0;
    int   errs   = 0;
    int   checks = 0;

    // MODULUS = 8 counter
    logic       reset_a = 1'b1, en_a = 1'b0, clear_a = 1'b0, load_a = 1'b0;
    logic [2:0] load_val_a = 3'd0;
    logic [2:0] q_a;
    logic       tc_a, wrapped_a, load_err_a;

    // MODULUS = 6 counter
    logic       reset_b = 1'b1, en_b = 1'b0, clear_b = 1'b0, load_b = 1'b0;
    logic [2:0] load_val_b = 3'd0;
    logic [2:0] q_b;
    logic       tc_b, wrapped_b, load_err_b;

    // Two-stage cascade
    logic       reset_c = 1'b1, en_c = 1'b0;
    logic       zero_c = 1'b0;
    logic [2:0] zval_c = 3'd0;
    logic [2:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, wrapped_lo, wrapped_hi, load_err_lo, load_err_hi;

    sync_up_counter_mod #(.WIDTH(3), .MODULUS(8)) dut_a (
        .clk(clk), .reset(reset_a), .en(en_a), .clear(clear_a), .load(load_a),
        .load_val(load_val_a), .q(q_a), .tc(tc_a), .wrapped(wrapped_a),
        .load_err(load_err_a));

    sync_up_counter_mod #(.WIDTH(3), .MODULUS(6)) dut_b (
        .clk(clk), .reset(reset_b), .en(en_b), .clear(clear_b), .load(load_b),
        .load_val(load_val_b), .q(q_b), .tc(tc_b), .wrapped(wrapped_b),
        .load_err(load_err_b));

    sync_up_counter_mod #(.WIDTH(3), .MODULUS(8)) dut_lo (
        .clk(clk), .reset(reset_c), .en(en_c), .clear(zero_c), .load(zero_c),
        .load_val(zval_c), .q(q_lo), .tc(tc_lo), .wrapped(wrapped_lo),
        .load_err(load_err_lo));

    sync_up_counter_mod #(.WIDTH(3), .MODULUS(8)) dut_hi (
        .clk(clk), .reset(reset_c), .en(tc_lo), .clear(zero_c), .load(zero_c),
        .load_val(zval_c), .q(q_hi), .tc(tc_hi), .wrapped(wrapped_hi),
        .load_err(load_err_hi));

    always #5 clk = ~clk;

    // Advance one rising edge. Inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- Reset then free run, MODULUS=8 ----
        tick(); tick();
        check("a_rst_q", int'(q_a), 0);
        check("a_rst_wrapped", int'(wrapped_a), 0);
        check("a_rst_load_err", int'(load_err_a), 0);
        check("a_rst_tc", int'(tc_a), 0);
        reset_a = 1'b0;
        en_a    = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            check($sformatf("a_run_q[%0d]", i), int'(q_a), i % 8);
            check($sformatf("a_run_wrapped[%0d]", i), int'(wrapped_a), (i == 8) ? 1 : 0);
            check($sformatf("a_run_tc[%0d]", i), int'(tc_a), (i % 8 == 7) ? 1 : 0);
            tick();
        end

        // ---- Truncated modulus 6, continuous enable ----
        reset_b = 1'b0;
        en_b    = 1'b1;
        for (int i = 0; i <= 13; i++) begin
            check($sformatf("b_run_q[%0d]", i), int'(q_b), i % 6);
            check($sformatf("b_run_wrapped[%0d]", i), int'(wrapped_b),
                  (i > 0 && i % 6 == 0) ? 1 : 0);
            check($sformatf("b_run_tc[%0d]", i), int'(tc_b), (i % 6 == 5) ? 1 : 0);
            tick();
        end

        // ---- Load handling, MODULUS=6 ----
        load_b = 1'b1; load_val_b = 3'd4; en_b = 1'b1;
        tick();
        load_b = 1'b0;
        check("b_load4_q", int'(q_b), 4);
        check("b_load4_err", int'(load_err_b), 0);
        tick();
        check("b_load4_next_q", int'(q_b), 5);
        check("b_load4_next_tc", int'(tc_b), 1);
        tick();
        check("b_load4_wrap_q", int'(q_b), 0);
        check("b_load4_wrap_w", int'(wrapped_b), 1);
        load_b = 1'b1; load_val_b = 3'd7; en_b = 1'b0;
        tick();
        load_b = 1'b0;
        check("b_load7_q", int'(q_b), 0);
        check("b_load7_err", int'(load_err_b), 1);
        check("b_load7_wrapped", int'(wrapped_b), 0);
        tick();
        check("b_load7_err_drop", int'(load_err_b), 0);
        check("b_load7_hold_q", int'(q_b), 0);
        // A load value equal to MODULUS is the first illegal one.
        load_b = 1'b1; load_val_b = 3'd6;
        tick();
        load_b = 1'b0;
        check("b_load6_q", int'(q_b), 0);
        check("b_load6_err", int'(load_err_b), 1);
        // A load of MODULUS-1 is still legal.
        load_b = 1'b1; load_val_b = 3'd5;
        tick();
        load_b = 1'b0;
        check("b_load5_q", int'(q_b), 5);
        check("b_load5_err", int'(load_err_b), 0);
        // Clear beats a load with an illegal value, so no error flag.
        clear_b = 1'b1; load_b = 1'b1; load_val_b = 3'd7;
        tick();
        clear_b = 1'b0; load_b = 1'b0;
        check("b_clr_ld7_q", int'(q_b), 0);
        check("b_clr_ld7_err", int'(load_err_b), 0);

        // ---- Priority and hold, MODULUS=8 ----
        en_a = 1'b0; load_a = 1'b1; load_val_a = 3'd3;
        tick();
        load_a = 1'b0;
        check("a_prio_setup_q", int'(q_a), 3);
        clear_a = 1'b1; load_a = 1'b1; load_val_a = 3'd2; en_a = 1'b1;
        tick();
        clear_a = 1'b0; load_a = 1'b0; en_a = 1'b0;
        check("a_prio_q", int'(q_a), 0);
        check("a_prio_err", int'(load_err_a), 0);
        check("a_prio_wrapped", int'(wrapped_a), 0);
        load_a = 1'b1; load_val_a = 3'd5;
        tick();
        load_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("a_hold_q[%0d]", i), int'(q_a), 5);
            check($sformatf("a_hold_tc[%0d]", i), int'(tc_a), 0);
        end
        // tc at the terminal count tracks en combinationally.
        load_a = 1'b1; load_val_a = 3'd7;
        tick();
        load_a = 1'b0;
        check("a_q7_en0_tc", int'(tc_a), 0);
        en_a = 1'b1;
        #1;
        check("a_q7_en1_tc", int'(tc_a), 1);
        en_a = 1'b0;

        // ---- Reset mid-operation ----
        load_a = 1'b1; load_val_a = 3'd6;
        tick();
        load_a = 1'b0;
        check("a_mid_setup_q", int'(q_a), 6);
        reset_a = 1'b1; en_a = 1'b1; load_a = 1'b1; load_val_a = 3'd2;
        tick();
        reset_a = 1'b0; load_a = 1'b0;
        check("a_mid_rst_q", int'(q_a), 0);
        check("a_mid_rst_wrapped", int'(wrapped_a), 0);
        check("a_mid_rst_err", int'(load_err_a), 0);
        tick();
        check("a_mid_resume_q1", int'(q_a), 1);
        tick();
        check("a_mid_resume_q2", int'(q_a), 2);

        // ---- Two-stage cascade ----
        tick(); tick();
        check("c_rst_q", int'({q_hi, q_lo}), 0);
        reset_c = 1'b0;
        en_c    = 1'b1;
        for (int i = 0; i <= 64; i++) begin
            check($sformatf("c_cnt[%0d]", i), int'({q_hi, q_lo}), i % 64);
            if (i % 8 == 7)
                check($sformatf("c_carry[%0d]", i), int'(tc_lo), 1);
            tick();
        end
        check("c_hi_wrapped", int'(wrapped_hi), 0);
        check("c_lo_wrapped", int'(wrapped_lo), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sync_up_counter_mod.md
Name: sync_up_counter_mod

Overview:
- Parameterized synchronous binary up counter, the counting-direction complement of the team's 3-bit synchronous down counter.
- Counts 0 -> MODULUS-1 and wraps to 0. Supports clock enable, synchronous clear, parallel load, and a carry-out for cascading stages into wider counters.
- Sits in the same counter library; used for event counting and as a timebase divider.

Parameters:
- WIDTH, 3, counter width in bits.
- MODULUS, 8, count length. Legal range 2..2**WIDTH. Count sequence is 0..MODULUS-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  count enable (also the carry-in when cascading)
- clear  input  1  synchronous clear to 0
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value to load
- q  output  WIDTH  registered count
- tc  output  1  carry-out: combinational, en AND (q == MODULUS-1)
- wrapped  output  1  registered; high for exactly one cycle after a wrap MODULUS-1 -> 0
- load_err  output  1  registered; high for one cycle after a load with load_val >= MODULUS

Behaviour:
- All state updates occur on the rising edge of clk only. No asynchronous paths.
- Reset values: q=0, wrapped=0, load_err=0. tc=0 whenever q != MODULUS-1.
- Per-edge priority, highest first: reset > clear > load > en.
  - reset: q<=0, wrapped<=0, load_err<=0.
  - clear: q<=0, wrapped<=0, load_err<=0.
  - load with load_val < MODULUS: q<=load_val, load_err<=0.
  - load with load_val >= MODULUS: q<=0, load_err<=1.
  - load: wrapped<=0 in both load cases.
  - en only: if q == MODULUS-1 then q<=0 and wrapped<=1, else q<=q+1 and wrapped<=0. load_err<=0.
  - none asserted: q holds; wrapped<=0; load_err<=0.
- Increment uses WIDTH-bit arithmetic. The MODULUS compare takes precedence over natural binary overflow.
  - With MODULUS = 2**WIDTH, the sequence is pure binary wrap, e.g. 7 -> 0 at WIDTH=3.
- Latency:
  - q changes one cycle after the qualifying edge.
  - tc is combinational from en and q, with no register stage, so cascaded stages increment in the same edge.
  - wrapped asserts in the cycle where q first reads 0 after a wrap.
- Cascading: stage N+1 en = stage N tc. The chain is fully synchronous, with no ripple clocking.
- Simultaneous events:
  - load and en together: load wins; no increment that edge.
  - clear and load together: clear wins, and load_err is not set even if load_val is illegal.
- Reset mid-count: the next edge forces q=0 regardless of en/load/clear.
- Out-of-range state: if q somehow holds a value >= MODULUS (not reachable by design), the next enabled edge forces q<=0. No wrapped pulse is generated in that case.
- tc is never asserted when en=0, even at q=MODULUS-1.
- Implementation:
  - Next-state logic built from gates/assigns feeding one D flip-flop per state bit, matching the flip-flop style used across the counter library.
  - q is driven directly from the flip-flops, with no inversion stage.

Test Plan:
- Reset then free run, WIDTH=3, MODULUS=8:
  - Stimulus: reset=1 for 2 cycles, then en=1 for 10 cycles.
  - Required: q reads 0,1,...,7,0,1. wrapped=1 only in the cycle q returns to 0. tc=1 only while q=7.
- Truncated modulus, MODULUS=6, en=1 continuously:
  - Required: q cycles 0..5,0. Values 6 and 7 never appear. tc high at q=5. wrapped pulses after 5 -> 0.
- Load handling, MODULUS=6:
  - Stimulus: load=1, load_val=4 with en=1.
  - Required: q=4 next cycle (no increment), then 5, 0.
  - Stimulus: load_val=7.
  - Required: q=0 and load_err=1 for exactly one cycle.
- Priority and hold:
  - Stimulus: at q=3, assert clear+load(load_val=2)+en together.
  - Required: q=0, load_err=0.
  - Stimulus: en=0 for 5 cycles at q=5 (MODULUS=8).
  - Required: q holds 5, tc=0.
- Cascade, two WIDTH=3 MODULUS=8 instances, upper en = lower tc:
  - Stimulus: 64 enabled cycles.
  - Required: combined {upper,lower} counts 0..63 and returns to 0. Upper increments in the same edge the lower wraps 7 -> 0.
- Reset mid-operation:
  - Stimulus: at q=6 with en=1 and load=1, load_val=2, assert reset for 1 cycle.
  - Required: q=0, wrapped=0, load_err=0 next cycle. Counting resumes 1,2,... once reset deasserts.
